twiddle_addr_mult: RTL

TWIDDLE_ADDR_MULT -- requirements
Module: twiddle_addr_mult

---
 rtl/twiddle_addr_mult_if.sv | 27 ++
 rtl/twiddle_addr_mult.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_addr_mult_if.sv
// Sample / twiddle-table / product bus of the twiddle address generator and
// complex multiplier. The master drives samples and answers table lookups; the
// slave (the multiplier) drives the table address and the products.
interface twiddle_addr_mult_if;
    logic               di_en;
    logic               di_sof;
    logic signed [17:0] di_re;
    logic signed [17:0] di_im;
    logic               inv;
    logic        [10:0] addr;
    logic signed [17:0] tw_re;
    logic signed [17:0] tw_im;
    logic               do_en;
    logic               do_last;
    logic signed [17:0] do_re;
    logic signed [17:0] do_im;

    modport master (
        output di_en, di_sof, di_re, di_im, inv, tw_re, tw_im,
        input  addr, do_en, do_last, do_re, do_im
    );

    modport slave (
        input  di_en, di_sof, di_re, di_im, inv, tw_re, tw_im,
        output addr, do_en, do_last, do_re, do_im
    );
endinterface

// File: rtl/twiddle_addr_mult.sv
// Twiddle index generator and complex multiplier for a 144-point frame laid out
// as N1 rows by N2 columns. Sample (r,c) is multiplied by twiddle index r*c mod
// 144, which is built incrementally (acc += r per column) so no multiplier is
// needed on the address path. The data path is input register -> partial
// products -> sum/round/saturate, plus TW_FF cycles of alignment in front.
module twiddle_addr_mult #(
    parameter int N1    = 12,
    parameter int N2    = 12,
    parameter int TW_FF = 0
) (
    input  logic               clk,
    input  logic               rst,
    twiddle_addr_mult_if.slave bus
);

    localparam logic [7:0]  C_LAST      = 8'(N2 - 1);
    localparam logic [7:0]  R_LAST      = 8'(N1 - 1);
    localparam logic [7:0]  C_AFTER_SOF = (N2 == 1) ? 8'd0 : 8'd1;
    localparam logic [11:0] FRAME       = 12'd144;

    // Negate with -full-scale clamped to +full-scale (conjugated twiddle).
    function automatic logic signed [17:0] neg_sat(input logic signed [17:0] x);
        if (x == 18'sh20000) return 18'sh1FFFF;
        else                 return -x;
    endfunction

    // Full-precision 18x18 signed product.
    function automatic logic signed [35:0] mul18(input logic signed [17:0] a,
                                                 input logic signed [17:0] b);
        return 36'(a) * 36'(b);
    endfunction

    // Sign-extend a product to the sum width.
    function automatic logic signed [36:0] sext36(input logic signed [35:0] x);
        return $signed({x[35], x});
    endfunction

    // Round half up at bit 10 (1.0 = 1024), then clamp to 18-bit signed range.
    function automatic logic signed [17:0] round_sat(input logic signed [36:0] s);
        logic signed [36:0] t;
        t = (s + 37'sd512) >>> 10;
        if (t > 37'sd131071)       return 18'sh1FFFF;
        else if (t < -37'sd131072) return 18'sh20000;
        else                       return t[17:0];
    endfunction

    logic        [7:0]  c_q, c_d, r_q, r_d;
    logic        [10:0] acc_q, acc_d, addr_s;
    logic        [11:0] acc_sum_s;
    logic               last_s;

    // Twiddle address: a start-of-frame sample always uses index 0.
    always_comb begin
        if (bus.di_en && bus.di_sof) addr_s = 11'd0;
        else                         addr_s = acc_q;
    end

    assign bus.addr = addr_s;

    // Frame position update and last-of-frame flag for the current sample.
    always_comb begin
        c_d       = c_q;
        r_d       = r_q;
        acc_d     = acc_q;
        last_s    = 1'b0;
        acc_sum_s = {1'b0, addr_s} + {4'd0, r_q};
        if (bus.di_en) begin
            if (bus.di_sof) begin
                c_d    = C_AFTER_SOF;
                r_d    = 8'd0;
                acc_d  = 11'd0;
                last_s = (R_LAST == 8'd0) && (C_LAST == 8'd0);
            end else if (c_q == C_LAST) begin
                c_d   = 8'd0;
                acc_d = 11'd0;
                if (r_q == R_LAST) r_d = 8'd0;
                else               r_d = r_q + 8'd1;
                last_s = (r_q == R_LAST);
            end else begin
                c_d = c_q + 8'd1;
                if (acc_sum_s >= FRAME) acc_d = 11'(acc_sum_s - FRAME);
                else                    acc_d = acc_sum_s[10:0];
            end
        end else begin
            c_d   = c_q;
            r_d   = r_q;
            acc_d = acc_q;
        end
    end

    // Frame position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q   <= 8'd0;
            r_q   <= 8'd0;
            acc_q <= 11'd0;
        end else begin
            c_q   <= c_d;
            r_q   <= r_d;
            acc_q <= acc_d;
        end
    end

    // Sample attributes as seen in the cycle the twiddle arrives.
    logic               al_en_s, al_inv_s, al_last_s;
    logic signed [17:0] al_re_s, al_im_s;

    generate
        if (TW_FF != 0) begin : g_tw_ff
            logic               dl_en_q, dl_inv_q, dl_last_q;
            logic signed [17:0] dl_re_q, dl_im_q;

            // Hold the sample one cycle while the registered table responds.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dl_en_q   <= 1'b0;
                    dl_inv_q  <= 1'b0;
                    dl_last_q <= 1'b0;
                    dl_re_q   <= 18'sd0;
                    dl_im_q   <= 18'sd0;
                end else begin
                    dl_en_q   <= bus.di_en;
                    dl_inv_q  <= bus.inv;
                    dl_last_q <= bus.di_en & last_s;
                    dl_re_q   <= bus.di_re;
                    dl_im_q   <= bus.di_im;
                end
            end

            assign al_en_s   = dl_en_q;
            assign al_inv_s  = dl_inv_q;
            assign al_last_s = dl_last_q;
            assign al_re_s   = dl_re_q;
            assign al_im_s   = dl_im_q;
        end else begin : g_tw_comb
            assign al_en_s   = bus.di_en;
            assign al_inv_s  = bus.inv;
            assign al_last_s = last_s;
            assign al_re_s   = bus.di_re;
            assign al_im_s   = bus.di_im;
        end
    endgenerate

    logic               v1_q, last1_q;
    logic signed [17:0] a1_q, b1_q, c1_q, d1_q;

    // Input register: data plus the twiddle, conjugated here for inverse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            a1_q    <= 18'sd0;
            b1_q    <= 18'sd0;
            c1_q    <= 18'sd0;
            d1_q    <= 18'sd0;
        end else begin
            v1_q    <= al_en_s;
            last1_q <= al_en_s & al_last_s;
            if (al_en_s) begin
                a1_q <= al_re_s;
                b1_q <= al_im_s;
                c1_q <= bus.tw_re;
                d1_q <= al_inv_s ? neg_sat(bus.tw_im) : bus.tw_im;
            end
        end
    end

    logic               v2_q, last2_q;
    logic signed [35:0] pp_ac_q, pp_bd_q, pp_ad_q, pp_bc_q;

    // Partial-product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            pp_ac_q <= 36'sd0;
            pp_bd_q <= 36'sd0;
            pp_ad_q <= 36'sd0;
            pp_bc_q <= 36'sd0;
        end else begin
            v2_q    <= v1_q;
            last2_q <= last1_q;
            if (v1_q) begin
                pp_ac_q <= mul18(a1_q, c1_q);
                pp_bd_q <= mul18(b1_q, d1_q);
                pp_ad_q <= mul18(a1_q, d1_q);
                pp_bc_q <= mul18(b1_q, c1_q);
            end
        end
    end

    logic signed [36:0] sum_re_s, sum_im_s;

    // Complex sums at full precision.
    always_comb begin
        sum_re_s = sext36(pp_ac_q) - sext36(pp_bd_q);
        sum_im_s = sext36(pp_ad_q) + sext36(pp_bc_q);
    end

    logic               do_en_q, do_last_q;
    logic signed [17:0] do_re_q, do_im_q;

    // Output register: round/saturate; data holds between valid samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_en_q   <= 1'b0;
            do_last_q <= 1'b0;
            do_re_q   <= 18'sd0;
            do_im_q   <= 18'sd0;
        end else begin
            do_en_q   <= v2_q;
            do_last_q <= v2_q & last2_q;
            if (v2_q) begin
                do_re_q <= round_sat(sum_re_s);
                do_im_q <= round_sat(sum_im_s);
            end
        end
    end

    assign bus.do_en   = do_en_q;
    assign bus.do_last = do_last_q;
    assign bus.do_re   = do_re_q;
    assign bus.do_im   = do_im_q;

endmodule
